// File: rtl/timer_irq_ctl_pkg.sv
// Shared definitions for the system-timer interrupt controller: FSM encoding and the
// default watchdog timeout derived from the global timer/clock constants.
package timer_irq_ctl_pkg;

   localparam int unsigned TIMER_CYCLE_MS = 20;
   localparam int unsigned CLK_SYS_HZ     = 50_000_000;

   // One tick period plus 20% margin, in clk_sys cycles.
   localparam int unsigned TIRQ_TIMEOUT_DEFAULT = TIMER_CYCLE_MS * (CLK_SYS_HZ / 1000) * 6 / 5;

   typedef enum logic [1:0] {
      TIRQ_IDLE = 2'd0,
      TIRQ_REQ  = 2'd1,
      TIRQ_ACKW = 2'd2
   } tirq_state_e;

endpackage

// File: rtl/timer_watchdog.sv
// Watchdog on the system-timer tick: raises a sticky timer_dead flag when no tick has
// been seen for TIMEOUT_CYCLES clocks; the next tick clears it.
module timer_watchdog
   import timer_irq_ctl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIRQ_TIMEOUT_DEFAULT
) (
   input  logic clk_sys,
   input  logic rst_n,
   input  logic zegar,
   output logic timer_dead
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] cnt_d, cnt_q;
   logic            dead_d, dead_q;

   always_comb begin
      cnt_d  = cnt_q;
      dead_d = dead_q;
      if (zegar) begin
         cnt_d  = '0;
         dead_d = 1'b0;
      end else if (cnt_q == CntLast) begin
         // Counter parks at the last value so the flag stays set without wrapping.
         dead_d = 1'b1;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         dead_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dead_q <= dead_d;
      end
   end

   assign timer_dead = dead_q;

endmodule

// File: rtl/timer_irq_ctl.sv
// Queues system-timer ticks and presents them as a level interrupt request with a
// 4-phase request/acknowledge handshake; counts ticks lost to queue overflow.
module timer_irq_ctl
   import timer_irq_ctl_pkg::*;
#(
   parameter int unsigned MAX_PEND       = 3,
   parameter int unsigned LOST_W         = 8,
   parameter int unsigned TIMEOUT_CYCLES = TIRQ_TIMEOUT_DEFAULT
) (
   input  logic                            clk_sys,
   input  logic                            rst_n,
   input  logic                            zegar,
   input  logic                            irq_mask,
   input  logic                            irq_ack,
   input  logic                            clr_lost,
   output logic                            irq_zeg,
   output logic [$clog2(MAX_PEND+1)-1:0]   pend_cnt,
   output logic [LOST_W-1:0]               lost_cnt,
   output logic                            timer_dead
);

   localparam int unsigned PendW = $clog2(MAX_PEND + 1);
   localparam logic [PendW-1:0] PendMax = PendW'(MAX_PEND);

   tirq_state_e       state_d, state_q;
   logic [PendW-1:0]  pend_d, pend_q;
   logic [LOST_W-1:0] lost_d, lost_q;
   logic              irq_d, irq_q;
   logic              pend_inc, pend_dec, lost_inc;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         TIRQ_IDLE: if (pend_q != '0 && irq_mask) state_d = TIRQ_REQ;
         TIRQ_REQ: begin
            if (irq_ack)        state_d = TIRQ_ACKW;
            else if (!irq_mask) state_d = TIRQ_IDLE;
         end
         TIRQ_ACKW: if (!irq_ack) state_d = TIRQ_IDLE;
         default:   state_d = TIRQ_IDLE;
      endcase
      irq_d = (state_d == TIRQ_REQ);
   end

   always_comb begin
      pend_inc = zegar;
      pend_dec = (state_q == TIRQ_REQ) && irq_ack;
      pend_d   = pend_q;
      lost_inc = 1'b0;
      // A tick coinciding with an acknowledge replaces the consumed entry, so no loss.
      if (pend_inc && !pend_dec) begin
         if (pend_q < PendMax) pend_d = pend_q + PendW'(1);
         else                  lost_inc = 1'b1;
      end else if (!pend_inc && pend_dec) begin
         pend_d = pend_q - PendW'(1);
      end

      lost_d = lost_q;
      if (clr_lost)                      lost_d = '0;
      else if (lost_inc && lost_q != '1) lost_d = lost_q + LOST_W'(1);
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         state_q <= TIRQ_IDLE;
         pend_q  <= '0;
         lost_q  <= '0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         lost_q  <= lost_d;
         irq_q   <= irq_d;
      end
   end

   timer_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_sys   (clk_sys),
      .rst_n     (rst_n),
      .zegar     (zegar),
      .timer_dead(timer_dead)
   );

   assign irq_zeg  = irq_q;
   assign pend_cnt = pend_q;
   assign lost_cnt = lost_q;

endmodule

// File: tb/tb_timer_irq_ctl.sv
// Directed bench for timer_irq_ctl with MAX_PEND=3, LOST_W=4, TIMEOUT_CYCLES=20.
module tb_timer_irq_ctl;

   logic       clk_sys = 1'b0;
   logic       rst_n, zegar, irq_mask, irq_ack, clr_lost;
   logic       irq_zeg, timer_dead;
   logic [1:0] pend_cnt;
   logic [3:0] lost_cnt;

   int n_vec = 0;
   int n_err = 0;
   int irq_rises = 0;
   logic irq_prev = 1'b0;

   always #5 clk_sys = ~clk_sys;

   timer_irq_ctl #(
      .MAX_PEND      (3),
      .LOST_W        (4),
      .TIMEOUT_CYCLES(20)
   ) dut (
      .clk_sys   (clk_sys),
      .rst_n     (rst_n),
      .zegar     (zegar),
      .irq_mask  (irq_mask),
      .irq_ack   (irq_ack),
      .clr_lost  (clr_lost),
      .irq_zeg   (irq_zeg),
      .pend_cnt  (pend_cnt),
      .lost_cnt  (lost_cnt),
      .timer_dead(timer_dead)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk_sys);
      #1;
      if (irq_zeg && !irq_prev) irq_rises++;
      irq_prev = irq_zeg;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; zegar = 1'b0; irq_mask = 1'b0; irq_ack = 1'b0; clr_lost = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic ticks(input int n);
      zegar = 1'b1;
      repeat (n) step();
      zegar = 1'b0;
   endtask

   initial begin
      do_reset();
      step();
      chk("rst_irq", irq_zeg, 0);
      chk("rst_pend", pend_cnt, 0);
      chk("rst_lost", lost_cnt, 0);
      chk("rst_dead", timer_dead, 0);

      // Watchdog: 20 edges without a tick after reset release sets timer_dead.
      do_reset();
      repeat (19) step();
      chk("wd_before", timer_dead, 0);
      step();
      chk("wd_set", timer_dead, 1);
      repeat (5) step();
      chk("wd_sticky", timer_dead, 1);
      ticks(1);
      chk("wd_clear", timer_dead, 0);
      chk("wd_tick_queued", pend_cnt, 1);

      // Basic handshake.
      do_reset();
      irq_mask = 1'b1;
      ticks(1);
      chk("hs_pend1", pend_cnt, 1);
      chk("hs_irq_lat1", irq_zeg, 0);
      step();
      chk("hs_irq_up", irq_zeg, 1);
      irq_ack = 1'b1;
      step();
      chk("hs_ack_irq", irq_zeg, 0);
      chk("hs_ack_pend", pend_cnt, 0);
      step(); step();
      chk("hs_ackw_hold", irq_zeg, 0);
      irq_ack = 1'b0;
      step(); step();
      chk("hs_idle_irq", irq_zeg, 0);
      chk("hs_idle_pend", pend_cnt, 0);

      // Mask drop in REQ withdraws the request but keeps the tick queued.
      ticks(1);
      step();
      chk("mask_req", irq_zeg, 1);
      irq_mask = 1'b0;
      step();
      chk("mask_withdraw", irq_zeg, 0);
      chk("mask_keep_pend", pend_cnt, 1);

      // Overflow while masked, then drain with three handshakes.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         ticks(1);
         chk("ovf_irq_low", irq_zeg, 0);
         step();
      end
      chk("ovf_pend", pend_cnt, 3);
      chk("ovf_lost", lost_cnt, 2);
      irq_rises = 0;
      irq_mask = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("drain_req", irq_zeg, 1);
         irq_ack = 1'b1;
         step();
         chk("drain_pend", pend_cnt, 32'(2 - i));
         irq_ack = 1'b0;
         step();
      end
      repeat (3) step();
      chk("drain_pend_end", pend_cnt, 0);
      chk("drain_rises", irq_rises, 3);

      // Simultaneous tick and acknowledge at full queue.
      do_reset();
      for (int i = 0; i < 3; i++) ticks(1);
      irq_mask = 1'b1;
      step();
      chk("sim_req", irq_zeg, 1);
      zegar = 1'b1; irq_ack = 1'b1;
      step();
      zegar = 1'b0;
      chk("sim_pend", pend_cnt, 3);
      chk("sim_lost", lost_cnt, 0);
      chk("sim_ackw", irq_zeg, 0);
      irq_ack = 1'b0;
      step(); step();
      chk("sim_rereq", irq_zeg, 1);

      // Saturation and clear priority.
      do_reset();
      ticks(20);
      chk("sat_pend", pend_cnt, 3);
      chk("sat_lost", lost_cnt, 15);
      zegar = 1'b1; clr_lost = 1'b1;
      step();
      clr_lost = 1'b0;
      chk("clr_prio", lost_cnt, 0);
      step();
      zegar = 1'b0;
      chk("clr_then_inc", lost_cnt, 1);

      // Reset while in REQ with pend=2, lost=5.
      do_reset();
      ticks(8);
      irq_mask = 1'b1;
      step();
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      step(); step();
      chk("mid_req", irq_zeg, 1);
      chk("mid_pend", pend_cnt, 2);
      chk("mid_lost", lost_cnt, 5);
      irq_ack = 1'b1; rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mid_rst_irq", irq_zeg, 0);
      chk("mid_rst_pend", pend_cnt, 0);
      chk("mid_rst_lost", lost_cnt, 0);
      repeat (3) step();
      chk("mid_ack_idle_irq", irq_zeg, 0);
      chk("mid_ack_idle_pend", pend_cnt, 0);
      ticks(1);
      chk("mid_tick_pend", pend_cnt, 1);
      step();
      chk("mid_req_despite_ack", irq_zeg, 1);
      step();
      chk("mid_ackw_irq", irq_zeg, 0);
      chk("mid_ackw_pend", pend_cnt, 0);
      irq_ack = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/timer_irq_ctl.md
Name: timer_irq_ctl

Overview:
- CPU-side consumer of the control-panel system-timer tick (`zegar`, a 1-cycle pulse every TIMER_CYCLE_MS).
- Queues ticks and presents them as a level interrupt request to the interrupt system, using a 4-phase request/acknowledge handshake.
- Counts ticks lost to queue overflow.
- Flags a dead or stopped timer with a watchdog.

Parameters:
- MAX_PEND, 3, maximum queued unacknowledged ticks (≥1).
- LOST_W, 8, width of the saturating lost-tick counter.
- TIMEOUT_CYCLES, 1_200_000, clk_sys cycles without a tick before `timer_dead` is set (20 ms @ 50 MHz + 20%).

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
- zegar  in  1  timer tick, 1-cycle pulse, synchronous to clk_sys.
- irq_mask  in  1  1 = timer interrupt enabled.
- irq_ack  in  1  interrupt acknowledge, level, 4-phase.
- clr_lost  in  1  1-cycle pulse, clears `lost_cnt`.
- irq_zeg  out  1  interrupt request, level.
- pend_cnt  out  $clog2(MAX_PEND+1)  queued ticks.
- lost_cnt  out  LOST_W  lost ticks, saturating.
- timer_dead  out  1  watchdog flag.

Behaviour:
- Reset (rst_n=0 at a clk_sys edge):
  - State IDLE; pend_cnt=0, lost_cnt=0, watchdog counter=0.
  - Outputs irq_zeg=0, timer_dead=0.
  - Reset overrides every other input in the same cycle, including mid-handshake.
- States: IDLE, REQ, ACKW (2-bit encoded). irq_zeg is registered and is 1 only in REQ.
- IDLE:
  - If pend_cnt≠0 and irq_mask=1 → REQ next cycle.
  - Latency from the tick cycle to irq_zeg=1 is 2 cycles: pend_cnt updates, then the state changes.
- REQ:
  - If irq_ack=1 → ACKW, and pend_cnt decrements by 1 in the same edge.
  - Else if irq_mask=0 → IDLE. The request is withdrawn and pend_cnt is kept.
- ACKW:
  - irq_zeg=0.
  - Stay until irq_ack=0, then → IDLE. A new request can rise at the earliest 1 cycle after that.
- Pending counter, per edge:
  - inc = zegar; dec = (state==REQ & irq_ack).
  - inc & dec: pend_cnt unchanged, no loss, even at MAX_PEND.
  - inc only: if pend_cnt<MAX_PEND then +1, else lost_cnt+1.
  - dec only: pend_cnt−1. dec never occurs with pend_cnt=0, by construction.
- lost_cnt:
  - Saturates at 2^LOST_W−1; never wraps.
  - clr_lost has priority over a simultaneous increment: result is 0.
- Watchdog:
  - Counter width $clog2(TIMEOUT_CYCLES+1).
  - zegar=1 clears the counter to 0 and clears timer_dead.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES−1, set timer_dead=1 on the next edge and hold the counter (no wrap).
  - timer_dead stays sticky until the next zegar.
- Masking:
  - irq_mask does not gate queuing; ticks still accumulate while masked.
  - irq_mask does not affect ACKW.
- irq_ack=1 in IDLE is ignored; the FSM still enters REQ if allowed, and ACKW then waits for irq_ack to drop.
- All outputs are registered. No combinational input→output paths.

Decomposition:
- Shared package:
  - State enum/localparams TIRQ_IDLE=2'd0, TIRQ_REQ=2'd1, TIRQ_ACKW=2'd2.
  - Default TIMEOUT derivation: TIMER_CYCLE_MS*(CLK_SYS_HZ/1000)*6/5, from the existing global constants.
- Sub-module: timer_watchdog, holding the timeout counter and the timer_dead flag. Its ports are clk_sys, rst_n, zegar, timer_dead.
- The FSM and counters stay in timer_irq_ctl.

Test Plan (MAX_PEND=3, LOST_W=4, TIMEOUT_CYCLES=20 unless noted):
- Basic handshake:
  - Stimulus: mask=1; zegar pulse at cycle 10; ack raised 1 cycle after irq_zeg=1, dropped 3 cycles later.
  - Response: pend_cnt=1 at 11; irq_zeg=1 at 12; on ack irq_zeg=0 and pend_cnt=0; back to IDLE 1 cycle after ack drops.
- Overflow:
  - Stimulus: mask=0; 5 zegar pulses 2 cycles apart.
  - Response: pend_cnt=3, lost_cnt=2, irq_zeg=0 throughout. Then mask=1 and 3 full handshakes bring pend_cnt to 0, with exactly 3 irq_zeg pulses.
- Simultaneous tick and ack:
  - Stimulus: pend_cnt=3, state REQ; zegar and ack in the same cycle.
  - Response: pend_cnt stays 3, lost_cnt unchanged, state ACKW.
- Saturation and clear:
  - Stimulus: 20 ticks with mask=0.
  - Response: lost_cnt=15 (saturated). Then clr_lost coincident with a further overflow tick gives lost_cnt=0.
- Watchdog:
  - Stimulus: no zegar for 25 cycles after reset.
  - Response: timer_dead=1 from cycle 20 onward; the next zegar clears it the next cycle.
- Reset mid-operation:
  - Stimulus: rst_n=0 for 1 cycle while in REQ with pend_cnt=2 and lost_cnt=5.
  - Response: all outputs 0 the next cycle; ack still high after reset causes no transition until a tick arrives.
